// File: rtl/acc_cpu_mc_pkg.sv
// Shared opcode/state definitions for the multi-cycle accumulator CPU.
// The optional immediate opcodes are enabled by ACC_CPU_MC_IMM_EN in the top module.
package acc_cpu_mc_pkg;

    localparam int OPW = 4;

    typedef enum logic [OPW-1:0] {
        OP_LDA  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_ORA  = 4'h4,
        OP_NOT  = 4'h5,
        OP_XOR  = 4'h6,
        OP_XNOR = 4'h7,
        OP_STA  = 4'h8,
        OP_JMP  = 4'h9,
        OP_JZ   = 4'hA,
        OP_JC   = 4'hB,
        OP_LDI  = 4'hC,
        OP_ADDI = 4'hD,
        OP_NOP  = 4'hE,
        OP_HLT  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_e;

    // Opcodes that need a data-memory access (loads, ALU ops with M, and store).
    function automatic logic is_mem_op(input opcode_e op);
        return (op <= OP_STA);
    endfunction

endpackage

// File: rtl/acc_cpu_mc_alu.sv
// Combinational ALU for the accumulator CPU: a is the accumulator, b the memory or immediate operand.
// Opcodes without an ALU meaning pass b through and hold the carry.
module acc_cpu_mc_alu
    import acc_cpu_mc_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [OPW-1:0] op,
    input  logic [DW-1:0]  a,
    input  logic [DW-1:0]  b,
    input  logic           c_in,
    output logic [DW-1:0]  result,
    output logic           c_out
);

    logic [DW-1:0] and_v;
    logic [DW-1:0] or_v;
    logic [DW-1:0] xor_v;
    logic [DW:0]   sum;
    logic [DW:0]   diff;

    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_bit
            assign and_v[gi] = a[gi] & b[gi];
            assign or_v[gi]  = a[gi] | b[gi];
            assign xor_v[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    // Both extended by one bit so the top bit is carry (ADD) or borrow (SUB).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = b;
        c_out  = c_in;
        case (opcode_e'(op))
            OP_LDA:  result = b;
            OP_ADD:  begin
                result = sum[DW-1:0];
                c_out  = sum[DW];
            end
            OP_SUB:  begin
                result = diff[DW-1:0];
                c_out  = diff[DW];
            end
            OP_AND:  result = and_v;
            OP_ORA:  result = or_v;
            OP_NOT:  result = ~b;
            OP_XOR:  result = xor_v;
            OP_XNOR: result = ~xor_v;
            default: result = b;
        endcase
    end

endmodule

// File: rtl/acc_cpu_mc.sv
// Multi-cycle accumulator CPU with req/ack instruction and data memory ports.
// Define ACC_CPU_MC_IMM_EN to make opcodes C/D execute LDI/ADDI; otherwise they act as NOP.
module acc_cpu_mc
    import acc_cpu_mc_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [AW-1:0]     imem_addr,
    input  logic [AW+3:0]     imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [AW-1:0]     dmem_addr,
    output logic [DW-1:0]     dmem_wdata,
    input  logic [DW-1:0]     dmem_rdata,
    input  logic              dmem_ack,
    output logic [DW-1:0]     acc_out,
    output logic [AW-1:0]     pc_out,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halted
);

    localparam int IW = AW + OPW;

    state_e         state_reg, state_next;
    logic [AW-1:0]  pc_reg, pc_next;
    logic [IW-1:0]  ir_reg, ir_next;
    logic [DW-1:0]  acc_reg, acc_next;
    logic           z_reg, z_next;
    logic           c_reg, c_next;

    opcode_e        ir_op;
    logic [AW-1:0]  ir_addr;
    logic [DW-1:0]  imm_ext;
    logic           is_imm;
    opcode_e        alu_op;
    logic [DW-1:0]  alu_b;
    logic [DW-1:0]  alu_result;
    logic           alu_c_out;

    assign ir_op   = opcode_e'(ir_reg[IW-1:AW]);
    assign ir_addr = ir_reg[AW-1:0];

    generate
        if (AW >= DW) begin : g_imm_trunc
            assign imm_ext = ir_addr[DW-1:0];
        end else begin : g_imm_pad
            assign imm_ext = {{(DW-AW){1'b0}}, ir_addr};
        end
    endgenerate

    // Immediates reuse the LDA/ADD datapath with the address field as operand.
    assign is_imm = (ir_op == OP_LDI) || (ir_op == OP_ADDI);
    assign alu_b  = is_imm ? imm_ext : dmem_rdata;

    always_comb begin
        alu_op = ir_op;
        if (ir_op == OP_LDI) begin
            alu_op = OP_LDA;
        end else if (ir_op == OP_ADDI) begin
            alu_op = OP_ADD;
        end
    end

    acc_cpu_mc_alu #(
        .DW(DW)
    ) u_alu (
        .op     (alu_op),
        .a      (acc_reg),
        .b      (alu_b),
        .c_in   (c_reg),
        .result (alu_result),
        .c_out  (alu_c_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_FETCH;
            pc_reg    <= '0;
            ir_reg    <= '0;
            acc_reg   <= '0;
            z_reg     <= 1'b0;
            c_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            acc_reg   <= acc_next;
            z_reg     <= z_next;
            c_reg     <= c_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        acc_next   = acc_reg;
        z_next     = z_reg;
        c_next     = c_reg;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;

        case (state_reg)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_next    = imem_rdata;
                    pc_next    = pc_reg + AW'(1);
                    state_next = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_next = ST_FETCH;
                if (is_mem_op(ir_op)) begin
                    state_next = ST_MEM;
                end else begin
                    case (ir_op)
                        OP_JMP: pc_next = ir_addr;
                        OP_JZ:  if (z_reg) pc_next = ir_addr;
                        OP_JC:  if (c_reg) pc_next = ir_addr;
`ifdef ACC_CPU_MC_IMM_EN
                        OP_LDI, OP_ADDI: begin
                            acc_next = alu_result;
                            z_next   = (alu_result == '0);
                            c_next   = alu_c_out;
                        end
`else
                        OP_LDI, OP_ADDI: state_next = ST_FETCH;
`endif
                        OP_HLT: state_next = ST_HALT;
                        default: state_next = ST_FETCH;
                    endcase
                end
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (ir_op == OP_STA);
                if (dmem_ack) begin
                    // Store leaves ACC and flags alone; the ALU holds C for non-arithmetic ops.
                    if (ir_op != OP_STA) begin
                        acc_next = alu_result;
                        z_next   = (alu_result == '0);
                        c_next   = alu_c_out;
                    end
                    state_next = ST_FETCH;
                end
            end

            ST_HALT: state_next = ST_HALT;

            default: state_next = ST_FETCH;
        endcase
    end

    assign imem_addr  = pc_reg;
    assign dmem_addr  = ir_addr;
    assign dmem_wdata = acc_reg;
    assign acc_out    = acc_reg;
    assign pc_out     = pc_reg;
    assign flag_z     = z_reg;
    assign flag_c     = c_reg;
    assign halted     = (state_reg == ST_HALT);

endmodule

// File: tb/tb_acc_cpu_mc.sv
// Self-checking bench for acc_cpu_mc: directed scenarios plus random forward-branching programs
// checked against an instruction-level model, with wait-state memory slaves.
module tb_acc_cpu_mc;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int IW = AW + 4;
    localparam int MS = 32;

    logic          clk;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          imem_ack;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;
    logic [DW-1:0] acc_out;
    logic [AW-1:0] pc_out;
    logic          flag_z;
    logic          flag_c;
    logic          halted;

    acc_cpu_mc #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .acc_out    (acc_out),
        .pc_out     (pc_out),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .halted     (halted)
    );

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] imem [MS];
    logic [DW-1:0] dmem [MS];
    logic [DW-1:0] ref_mem [MS];
    int imem_wait = 0;
    int dmem_wait = 0;
    int icnt = 0;
    int dcnt = 0;

    // Model results
    int m_acc, m_z, m_c, m_pc, m_cycles;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory slaves: ack is decided mid-cycle from the request and the wait counter.
    always @(negedge clk) begin
        imem_ack   = imem_req && (icnt >= imem_wait);
        imem_rdata = imem_ack ? imem[imem_addr] : '0;
        dmem_ack   = dmem_req && (dcnt >= dmem_wait);
        dmem_rdata = dmem_ack ? dmem[dmem_addr] : DW'($urandom);
    end

    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) icnt = 0; else icnt = icnt + 1;
        if (rst || !dmem_req || dmem_ack) dcnt = 0; else dcnt = dcnt + 1;
        if (!rst && dmem_req && dmem_we && dmem_ack) dmem[dmem_addr] = dmem_wdata;
    end

    function automatic logic [IW-1:0] ins(input int op, input int a);
        return IW'((op << AW) | a);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mems();
        for (int i = 0; i < MS; i++) begin
            imem[i] = ins(14, 0);
            dmem[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    // Instruction-level reference: runs the program in imem from PC 0 until HLT, zero-wait timing.
    task automatic model_run();
        int acc, pc, z, c, cyc, op, a, m, t;
        bit done;
        logic [IW-1:0] w;
        acc = 0; pc = 0; z = 0; c = 0; cyc = 0; done = 0;
        for (int i = 0; i < MS; i++) ref_mem[i] = dmem[i];
        for (int s = 0; s < 200 && !done; s++) begin
            w  = imem[pc];
            op = int'(w[IW-1:AW]);
            a  = int'(w[AW-1:0]);
            pc = (pc + 1) % MS;
            m  = int'(ref_mem[a]);
            if (op <= 8) cyc += 3; else cyc += 2;
            case (op)
                0: acc = m;
                1: begin t = acc + m; c = (t > 255) ? 1 : 0; acc = t % 256; end
                2: begin c = (acc < m) ? 1 : 0; acc = (acc - m + 256) % 256; end
                3: acc = acc & m;
                4: acc = acc | m;
                5: acc = 255 - m;
                6: acc = acc ^ m;
                7: acc = 255 - (acc ^ m);
                8: ref_mem[a] = DW'(acc);
                9: pc = a;
                10: if (z != 0) pc = a;
                11: if (c != 0) pc = a;
`ifdef ACC_CPU_MC_IMM_EN
                12: acc = a;
                13: begin t = acc + a; c = (t > 255) ? 1 : 0; acc = t % 256; end
`endif
                15: done = 1;
                default: ;
            endcase
            if (op <= 7 || op == 12 || op == 13) begin
`ifdef ACC_CPU_MC_IMM_EN
                z = (acc == 0) ? 1 : 0;
`else
                if (op <= 7) z = (acc == 0) ? 1 : 0;
`endif
            end
        end
        m_acc = acc; m_z = z; m_c = c; m_pc = pc; m_cycles = cyc;
    endtask

    task automatic test_reset();
        clear_mems();
        imem_wait = 0; dmem_wait = 0;
        do_reset();
        checks++; if (pc_out !== 5'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", pc_out); end
        checks++; if (acc_out !== 8'h00) begin errors++; $display("FAIL reset_acc: got %h expected 00", acc_out); end
        checks++; if (flag_z !== 1'b0 || flag_c !== 1'b0) begin errors++; $display("FAIL reset_flags: got z=%b c=%b expected 0 0", flag_z, flag_c); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin errors++; $display("FAIL reset_dmem_req: got req=%b we=%b expected 0 0", dmem_req, dmem_we); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 5'd0) begin errors++; $display("FAIL reset_fetch: got req=%b addr=%0d expected 1 0", imem_req, imem_addr); end
        $display("test_reset done");
    endtask

    task automatic test_basic_program();
        clear_mems();
        imem[0] = ins(0, 0); imem[1] = ins(1, 1); imem[2] = ins(8, 5); imem[3] = ins(15, 0);
        dmem[0] = 8'd1; dmem[1] = 8'd2;
        do_reset();
        step(10);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL basic_halt_early: got %b expected 0 at cycle 10", halted); end
        step(1);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL basic_halt: got %b expected 1 at cycle 11", halted); end
        checks++; if (dmem[5] !== 8'd3) begin errors++; $display("FAIL basic_store: got %h expected 03", dmem[5]); end
        checks++; if (acc_out !== 8'd3 || flag_z !== 1'b0 || flag_c !== 1'b0) begin errors++; $display("FAIL basic_acc: got acc=%h z=%b c=%b expected 03 0 0", acc_out, flag_z, flag_c); end
        checks++; if (imem_req !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL basic_halt_req: got i=%b d=%b expected 0 0", imem_req, dmem_req); end
        $display("test_basic_program acc=%h m5=%h", acc_out, dmem[5]);
    endtask

    task automatic test_carry_branch();
        clear_mems();
        imem[0] = ins(0, 0); imem[1] = ins(1, 1); imem[2] = ins(10, 10);
        imem[10] = ins(11, 20); imem[20] = ins(15, 0);
        dmem[0] = 8'hFF; dmem[1] = 8'h01;
        do_reset();
        step(6);
        checks++; if (acc_out !== 8'h00 || flag_z !== 1'b1 || flag_c !== 1'b1) begin errors++; $display("FAIL add_carry: got acc=%h z=%b c=%b expected 00 1 1", acc_out, flag_z, flag_c); end
        step(2);
        checks++; if (imem_addr !== 5'd10 || imem_req !== 1'b1) begin errors++; $display("FAIL jz_taken: got addr=%0d req=%b expected 10 1", imem_addr, imem_req); end
        step(2);
        checks++; if (imem_addr !== 5'd20) begin errors++; $display("FAIL jc_taken: got addr=%0d expected 20", imem_addr); end
        step(2);
        checks++; if (halted !== 1'b1 || pc_out !== 5'd21) begin errors++; $display("FAIL branch_halt: got halted=%b pc=%0d expected 1 21", halted, pc_out); end
        $display("test_carry_branch pc=%0d", pc_out);
    endtask

    task automatic test_sub_borrow();
        clear_mems();
        imem[0] = ins(0, 0); imem[1] = ins(2, 1); imem[2] = ins(0, 2); imem[3] = ins(15, 0);
        dmem[0] = 8'h01; dmem[1] = 8'h02; dmem[2] = 8'h00;
        do_reset();
        step(6);
        checks++; if (acc_out !== 8'hFF || flag_c !== 1'b1 || flag_z !== 1'b0) begin errors++; $display("FAIL sub_borrow: got acc=%h z=%b c=%b expected ff 0 1", acc_out, flag_z, flag_c); end
        step(3);
        checks++; if (acc_out !== 8'h00 || flag_z !== 1'b1 || flag_c !== 1'b1) begin errors++; $display("FAIL lda_holds_c: got acc=%h z=%b c=%b expected 00 1 1", acc_out, flag_z, flag_c); end
        $display("test_sub_borrow acc=%h", acc_out);
    endtask

    task automatic test_wait_states();
        clear_mems();
        imem[0] = ins(0, 0); imem[1] = ins(1, 1); imem[2] = ins(15, 0);
        dmem[0] = 8'h10; dmem[1] = 8'h22;
        imem_wait = 0; dmem_wait = 3;
        do_reset();
        step(8);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dmem_req !== 1'b1 || dmem_addr !== 5'd1 || dmem_we !== 1'b0 || acc_out !== 8'h10) begin
                errors++;
                $display("FAIL wait_hold[%0d]: got req=%b addr=%0d we=%b acc=%h expected 1 1 0 10", k, dmem_req, dmem_addr, dmem_we, acc_out);
            end
            step(1);
        end
        checks++; if (dmem_req !== 1'b0 || acc_out !== 8'h32) begin errors++; $display("FAIL wait_release: got req=%b acc=%h expected 0 32", dmem_req, acc_out); end
        dmem_wait = 0;
        $display("test_wait_states acc=%h", acc_out);
    endtask

    task automatic test_pc_wrap();
        clear_mems();
        imem[0] = ins(9, 31); imem[31] = ins(14, 0);
        do_reset();
        step(2);
        checks++; if (imem_addr !== 5'd31 || pc_out !== 5'd31) begin errors++; $display("FAIL jmp31: got addr=%0d pc=%0d expected 31 31", imem_addr, pc_out); end
        step(2);
        checks++; if (imem_addr !== 5'd0 || pc_out !== 5'd0 || imem_req !== 1'b1) begin errors++; $display("FAIL pc_wrap: got addr=%0d pc=%0d req=%b expected 0 0 1", imem_addr, pc_out, imem_req); end
        $display("test_pc_wrap pc=%0d", pc_out);
    endtask

    task automatic test_reset_mid();
        clear_mems();
        imem[0] = ins(0, 0); imem[1] = ins(0, 1);
        dmem[0] = 8'h5A; dmem[1] = 8'hA5;
        imem_wait = 0; dmem_wait = 2;
        do_reset();
        step(5);
        checks++; if (acc_out !== 8'h5A) begin errors++; $display("FAIL mid_pre_acc: got %h expected 5a", acc_out); end
        step(2);
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL mid_req_up: got %b expected 1", dmem_req); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checks++; if (dmem_req !== 1'b0 || pc_out !== 5'd0 || acc_out !== 8'h00 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got dreq=%b pc=%0d acc=%h ireq=%b expected 0 0 00 1", dmem_req, pc_out, acc_out, imem_req);
        end
        dmem_wait = 0;
        $display("test_reset_mid done");
    endtask

    task automatic test_imm();
        logic [DW-1:0] exp_acc;
        clear_mems();
        imem[0] = ins(0, 0); imem[1] = ins(12, 7);
        dmem[0] = 8'h33;
`ifdef ACC_CPU_MC_IMM_EN
        exp_acc = 8'h07;
`else
        exp_acc = 8'h33;
`endif
        do_reset();
        step(3);
        checks++; if (acc_out !== 8'h33) begin errors++; $display("FAIL imm_pre: got %h expected 33", acc_out); end
        step(1);
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL imm_no_dmem: got %b expected 0", dmem_req); end
        step(1);
        checks++; if (acc_out !== exp_acc || dmem_req !== 1'b0 || imem_addr !== 5'd2 || flag_z !== 1'b0) begin
            errors++;
            $display("FAIL imm_ldi: got acc=%h dreq=%b addr=%0d z=%b expected %h 0 2 0", acc_out, dmem_req, imem_addr, flag_z, exp_acc);
        end
        $display("test_imm acc=%h", acc_out);
    endtask

    task automatic test_random_programs();
        int op, nbad, bad_i, cyc;
        for (int p = 0; p < 16; p++) begin
            clear_mems();
            for (int i = 0; i < MS - 1; i++) begin
                op = $urandom_range(0, 15);
                if (op == 15 && $urandom_range(0, 3) != 0) op = 1;
                if (op >= 9 && op <= 11) imem[i] = ins(op, $urandom_range(i + 1, MS - 1));
                else imem[i] = ins(op, $urandom_range(0, MS - 1));
            end
            imem[MS-1] = ins(15, 0);
            for (int i = 0; i < MS; i++) dmem[i] = DW'($urandom);
            if (p < 8) begin
                imem_wait = 0; dmem_wait = 0;
            end else begin
                imem_wait = $urandom_range(0, 2); dmem_wait = $urandom_range(0, 3);
            end
            model_run();
            do_reset();
            if (p < 8) begin
                step(m_cycles - 1);
                checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rand%0d_early_halt: got 1 expected 0 at cycle %0d", p, m_cycles - 1); end
                step(1);
                checks++; if (halted !== 1'b1) begin errors++; $display("FAIL rand%0d_halt_cycle: got 0 expected 1 at cycle %0d", p, m_cycles); end
            end else begin
                cyc = 0;
                while (halted !== 1'b1 && cyc < 3000) begin
                    step(1);
                    cyc++;
                end
                checks++; if (halted !== 1'b1) begin errors++; $display("FAIL rand%0d_timeout: halted=%b expected 1 within 3000 cycles", p, halted); end
            end
            checks++;
            if (acc_out !== DW'(m_acc) || flag_z !== m_z[0] || flag_c !== m_c[0] || pc_out !== AW'(m_pc)) begin
                errors++;
                $display("FAIL rand%0d_state: got acc=%h z=%b c=%b pc=%0d expected %h %0d %0d %0d", p, acc_out, flag_z, flag_c, pc_out, m_acc, m_z, m_c, m_pc);
            end
            nbad = 0; bad_i = 0;
            for (int i = 0; i < MS; i++) begin
                if (dmem[i] !== ref_mem[i]) begin
                    if (nbad == 0) bad_i = i;
                    nbad++;
                end
            end
            checks++;
            if (nbad != 0) begin
                errors++;
                $display("FAIL rand%0d_dmem: %0d words differ, m[%0d] got %h expected %h", p, nbad, bad_i, dmem[bad_i], ref_mem[bad_i]);
            end
            $display("random program %0d waits i=%0d d=%0d acc=%h pc=%0d cycles=%0d", p, imem_wait, dmem_wait, acc_out, pc_out, m_cycles);
        end
        imem_wait = 0; dmem_wait = 0;
    endtask

    initial begin
        rst = 1'b1;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        imem_rdata = '0; dmem_rdata = '0;
        test_reset();
        test_basic_program();
        test_carry_branch();
        test_sub_borrow();
        test_wait_states();
        test_pc_wrap();
        test_reset_mid();
        test_imm();
        test_random_programs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
